sci_master_sequencer: RTL and testbench



---
 rtl/sci_pkg.sv | 29 ++
 rtl/sci_master_sequencer_if.sv | 63 ++++++
 rtl/sci_sync_fifo.sv | 52 +++++
 rtl/sci_master_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_sci_master_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sci_pkg.sv
// sci_pkg: shared types and helpers for the SCI master sequencer
// FSM states, one-hot-low chip select decode, response record width
package sci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_GAP
  } state_e;

  function automatic logic [31:0] pid_to_csn(
    input logic [4:0] pid
  );
    logic [31:0] r;
    r      = '1;
    r[pid] = 1'b0;
    return r;
  endfunction

  // response record: {data, pid, err}
  function automatic int unsigned rsp_rec_w(
    input int unsigned dw,
    input int unsigned pw
  );
    return dw + pw + 1;
  endfunction

endpackage

// File: rtl/sci_master_sequencer_if.sv
// sci_master_sequencer_if: command, response and master-bus bundle
// slave modport is the sequencer view, master modport the driver view
interface sci_master_sequencer_if #(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_PERIPHERALS = 4,
  parameter int PID_WIDTH       = $clog2(NUM_PERIPHERALS)
);

  logic                       CMD_VALID;
  logic                       CMD_READY;
  logic                       CMD_WNR;
  logic [PID_WIDTH-1:0]       CMD_PID;
  logic [ADDR_WIDTH-1:0]      CMD_ADDR;
  logic [DATA_WIDTH-1:0]      CMD_DATA;

  logic                       RSP_VALID;
  logic                       RSP_READY;
  logic [DATA_WIDTH-1:0]      RSP_DATA;
  logic [PID_WIDTH-1:0]       RSP_PID;
  logic                       RSP_ERR;

  logic                       M_REQ;
  logic                       M_WNR;
  logic [ADDR_WIDTH-1:0]      M_ADDR;
  logic [NUM_PERIPHERALS-1:0] M_CSN;
  logic [DATA_WIDTH-1:0]      M_DATA;
  logic                       M_ACK;
  logic [DATA_WIDTH-1:0]      M_RDATA;

  logic                       BUSY;
  logic                       TIMEOUT_ERR;
  logic                       ERR_CLR;

  modport slave (
    input  CMD_VALID, CMD_WNR, CMD_PID,
    input  CMD_ADDR, CMD_DATA,
    output CMD_READY,
    input  RSP_READY,
    output RSP_VALID, RSP_DATA,
    output RSP_PID, RSP_ERR,
    output M_REQ, M_WNR, M_ADDR,
    output M_CSN, M_DATA,
    input  M_ACK, M_RDATA,
    output BUSY, TIMEOUT_ERR,
    input  ERR_CLR
  );

  modport master (
    output CMD_VALID, CMD_WNR, CMD_PID,
    output CMD_ADDR, CMD_DATA,
    input  CMD_READY,
    output RSP_READY,
    input  RSP_VALID, RSP_DATA,
    input  RSP_PID, RSP_ERR,
    input  M_REQ, M_WNR, M_ADDR,
    input  M_CSN, M_DATA,
    output M_ACK, M_RDATA,
    input  BUSY, TIMEOUT_ERR,
    output ERR_CLR
  );

endinterface

// File: rtl/sci_sync_fifo.sv
// sci_sync_fifo: first-word-fall-through synchronous queue
// push while full is taken only when a pop frees the slot the same cycle
module sci_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = r_count == (AW+1)'(DEPTH);
  assign empty  = r_count == '0;
  assign count  = r_count;
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  // empty reads as zero so the payload has a defined reset value
  assign rdata  = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push)
                         - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/sci_master_sequencer.sv
// sci_master_sequencer: queues commands onto SCI_MASTER REQ/ACK
// reads reserve a response slot before issue, so the rsp queue never overflows
module sci_master_sequencer #(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_PERIPHERALS = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 4,
  parameter int ACK_TIMEOUT     = 64
) (
  input logic                   CLK,
  input logic                   RSTN,
  sci_master_sequencer_if.slave bus
);

  import sci_pkg::*;

  localparam int PW    = $clog2(NUM_PERIPHERALS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CMD_W = 1 + PW + ADDR_WIDTH + DATA_WIDTH;
  localparam int RSP_W = rsp_rec_w(DATA_WIDTH, PW);
  localparam int CW_T  = $clog2(ACK_TIMEOUT + 1);
  localparam int CW_G  = $clog2(GAP_CYCLES + 1);
  localparam int CW_A  = CW_T > CW_G ? CW_T : CW_G;
  localparam int CW    = CW_A > 0 ? CW_A : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'(ACK_TIMEOUT > 0 ? ACK_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_e                     r_state;
  logic                       r_req;
  logic                       r_wnr;
  logic [ADDR_WIDTH-1:0]      r_addr;
  logic [DATA_WIDTH-1:0]      r_data;
  logic [NUM_PERIPHERALS-1:0] r_csn;
  logic [PW-1:0]              r_pid;
  logic                       r_rd_pend;
  logic [CW-1:0]              r_cnt;
  logic                       r_ack_q;
  logic                       r_terr;

  logic                       w_cmd_push;
  logic                       w_cmd_full;
  logic                       w_cmd_empty;
  logic [AW:0]                w_cmd_count;
  logic [CMD_W-1:0]           w_cmd_wdata;
  logic [CMD_W-1:0]           w_cmd_rdata;
  logic                       w_hd_wnr;
  logic [PW-1:0]              w_hd_pid;
  logic [ADDR_WIDTH-1:0]      w_hd_addr;
  logic [DATA_WIDTH-1:0]      w_hd_data;
  logic                       w_hd_bad;

  logic                       w_rsp_push;
  logic                       w_rsp_pop;
  logic                       w_rsp_full;
  logic                       w_rsp_empty;
  logic [AW:0]                w_rsp_count;
  logic [RSP_W-1:0]           w_rsp_wdata;
  logic [RSP_W-1:0]           w_rsp_rdata;
  logic                       w_rsp_slot;

  logic                       w_pop;
  logic                       w_ack_edge;
  logic                       w_done_ack;
  logic                       w_to_hit;
  logic                       w_bad_rd;

  assign w_cmd_wdata = {bus.CMD_WNR, bus.CMD_PID,
                        bus.CMD_ADDR, bus.CMD_DATA};
  assign {w_hd_wnr, w_hd_pid, w_hd_addr, w_hd_data} = w_cmd_rdata;
  assign w_cmd_push  = bus.CMD_VALID && !w_cmd_full;
  assign w_hd_bad    = 32'(w_hd_pid) >= 32'(NUM_PERIPHERALS);

  assign w_rsp_pop   = bus.RSP_READY && !w_rsp_empty;
  assign w_rsp_slot  = !w_rsp_full &&
    ((32'(w_rsp_count) + 32'(r_rd_pend)) < 32'(FIFO_DEPTH));

  assign w_pop      = (r_state == ST_IDLE) && !w_cmd_empty &&
                      (w_hd_wnr || w_rsp_slot);
  assign w_ack_edge = bus.M_ACK && !r_ack_q;
  assign w_done_ack = (r_state == ST_WAIT_ACK) && w_ack_edge;
  assign w_to_hit   = (r_state == ST_WAIT_ACK) && !w_ack_edge &&
                      (ACK_TIMEOUT != 0) && (r_cnt == TO_LAST);
  assign w_bad_rd   = w_pop && w_hd_bad && !w_hd_wnr;

  sci_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_q (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (w_cmd_push),
    .wdata (w_cmd_wdata),
    .pop   (w_pop),
    .rdata (w_cmd_rdata),
    .full  (w_cmd_full),
    .empty (w_cmd_empty),
    .count (w_cmd_count)
  );

  sci_sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_q (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (w_rsp_push),
    .wdata (w_rsp_wdata),
    .pop   (w_rsp_pop),
    .rdata (w_rsp_rdata),
    .full  (w_rsp_full),
    .empty (w_rsp_empty),
    .count (w_rsp_count)
  );

  always_comb begin
    w_rsp_push  = 1'b0;
    w_rsp_wdata = '0;
    unique case (1'b1)
      w_bad_rd: begin
        w_rsp_push  = 1'b1;
        w_rsp_wdata = {{DATA_WIDTH{1'b0}}, w_hd_pid, 1'b1};
      end
      (r_rd_pend && w_done_ack): begin
        w_rsp_push  = 1'b1;
        w_rsp_wdata = {bus.M_RDATA, r_pid, 1'b0};
      end
      (r_rd_pend && w_to_hit): begin
        w_rsp_push  = 1'b1;
        w_rsp_wdata = {{DATA_WIDTH{1'b0}}, r_pid, 1'b1};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_wnr     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_csn     <= '1;
      r_pid     <= '0;
      r_rd_pend <= 1'b0;
      r_cnt     <= '0;
      r_ack_q   <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      r_ack_q <= bus.M_ACK;
      if (w_to_hit)         r_terr <= 1'b1;
      else if (bus.ERR_CLR) r_terr <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // out-of-range pids are consumed without touching the bus
          if (w_pop && !w_hd_bad) begin
            r_wnr     <= w_hd_wnr;
            r_addr    <= w_hd_addr;
            r_data    <= w_hd_data;
            r_pid     <= w_hd_pid;
            r_csn     <= NUM_PERIPHERALS'(
                           pid_to_csn(5'(w_hd_pid)));
            r_rd_pend <= !w_hd_wnr;
            r_req     <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_req   <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (w_done_ack || w_to_hit) begin
            r_rd_pend <= 1'b0;
            r_cnt     <= '0;
            if (GAP_CYCLES == 0) begin
              r_csn   <= '1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_GAP;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_csn   <= '1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.CMD_READY   = !w_cmd_full;
  assign bus.RSP_VALID   = !w_rsp_empty;
  assign {bus.RSP_DATA, bus.RSP_PID, bus.RSP_ERR} = w_rsp_rdata;
  assign bus.M_REQ       = r_req;
  assign bus.M_WNR       = r_wnr;
  assign bus.M_ADDR      = r_addr;
  assign bus.M_DATA      = r_data;
  assign bus.M_CSN       = r_csn;
  assign bus.BUSY        = (r_state != ST_IDLE) || (w_cmd_count != '0);
  assign bus.TIMEOUT_ERR = r_terr;

endmodule

// File: tb/tb_sci_master_sequencer.sv
// tb_sci_master_sequencer: directed bench with a small SCI slave model
// u_dut0 runs GAP=4/TIMEOUT=16, u_dut1 runs GAP=0
module tb_sci_master_sequencer;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  sci_master_sequencer_if #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_PERIPHERALS(4)
  ) bus0 ();
  sci_master_sequencer_if #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_PERIPHERALS(4)
  ) bus1 ();

  sci_master_sequencer #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_PERIPHERALS(4),
    .FIFO_DEPTH(4), .GAP_CYCLES(4), .ACK_TIMEOUT(16)
  ) u_dut0 (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus0)
  );

  sci_master_sequencer #(
    .ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_PERIPHERALS(4),
    .FIFO_DEPTH(4), .GAP_CYCLES(0), .ACK_TIMEOUT(16)
  ) u_dut1 (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus1)
  );

  logic       s_ack;
  logic       man_ack;
  logic       man_ack1;
  logic       ack_en;
  logic [7:0] s_rdata;
  logic [7:0] mem [4][16];

  assign bus0.M_ACK   = s_ack | man_ack;
  assign bus0.M_RDATA = s_rdata;
  assign bus1.M_ACK   = man_ack1;
  assign bus1.M_RDATA = 8'h00;

  int   req_cnt0  = 0;
  logic req_prev0 = 1'b0;
  always @(negedge clk) begin
    if (bus0.M_REQ && !req_prev0) req_cnt0++;
    req_prev0 = bus0.M_REQ;
  end

  function automatic int csn_pid(input logic [3:0] csn);
    csn_pid = 0;
    for (int i = 0; i < 4; i++)
      if (!csn[i]) csn_pid = i;
  endfunction

  // slave + memory: ACK two cycles after REQ, held two cycles
  initial begin
    int         p;
    logic [3:0] a;
    s_ack   = 1'b0;
    s_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus0.M_REQ && ack_en) begin
        p = csn_pid(bus0.M_CSN);
        a = bus0.M_ADDR;
        repeat (2) @(negedge clk);
        if (bus0.M_WNR) mem[p][a] = bus0.M_DATA;
        else            s_rdata   = mem[p][a];
        s_ack = 1'b1;
        repeat (2) @(negedge clk);
        s_ack = 1'b0;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic push0(input logic wnr, input logic [1:0] pid,
                       input logic [3:0] addr, input logic [7:0] data,
                       output logic acc);
    bus0.CMD_VALID = 1'b1;
    bus0.CMD_WNR   = wnr;
    bus0.CMD_PID   = pid;
    bus0.CMD_ADDR  = addr;
    bus0.CMD_DATA  = data;
    acc = bus0.CMD_READY;
    @(negedge clk);
    bus0.CMD_VALID = 1'b0;
  endtask

  task automatic wait_req0(input string tag, input int lim);
    int k = 0;
    while (!bus0.M_REQ && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(tag, bus0.M_REQ, 1);
  endtask

  task automatic wait_idle0(input string tag, input int lim);
    int k = 0;
    while (bus0.BUSY && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(tag, bus0.BUSY, 0);
  endtask

  task automatic pop0();
    bus0.RSP_READY = 1'b1;
    @(negedge clk);
    bus0.RSP_READY = 1'b0;
  endtask

  initial begin
    logic acc;
    int   k;
    int   c0;
    int   nacc;
    rstn     = 1'b0;
    man_ack  = 1'b0;
    man_ack1 = 1'b0;
    ack_en   = 1'b0;
    bus0.CMD_VALID = 0; bus0.CMD_WNR = 0; bus0.CMD_PID = 0;
    bus0.CMD_ADDR  = 0; bus0.CMD_DATA = 0;
    bus0.RSP_READY = 0; bus0.ERR_CLR = 0;
    bus1.CMD_VALID = 0; bus1.CMD_WNR = 0; bus1.CMD_PID = 0;
    bus1.CMD_ADDR  = 0; bus1.CMD_DATA = 0;
    bus1.RSP_READY = 0; bus1.ERR_CLR = 0;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 16; a++)
        mem[p][a] = 8'(16 * p + a);

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus0.CMD_READY, 1);
    check("rst_rsp", {bus0.RSP_VALID, bus0.RSP_ERR,
                      bus0.RSP_PID, bus0.RSP_DATA}, 0);
    check("rst_mbus", {bus0.M_REQ, bus0.M_WNR,
                       bus0.M_ADDR, bus0.M_DATA}, 0);
    check("rst_csn", bus0.M_CSN, 4'hF);
    check("rst_flags", {bus0.BUSY, bus0.TIMEOUT_ERR}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // write/read round trip
    ack_en = 1'b1;
    @(negedge clk);
    push0(1'b1, 2'd2, 4'h5, 8'hA7, acc);
    wait_req0("rt_wr_req", 10);
    check("rt_wr_csn", bus0.M_CSN, 4'b1011);
    check("rt_wr_wnr", bus0.M_WNR, 1);
    push0(1'b0, 2'd2, 4'h5, 8'h00, acc);
    check("rt_wr_pulse", bus0.M_REQ, 0);
    wait_req0("rt_rd_req", 40);
    check("rt_rd_csn", bus0.M_CSN, 4'b1011);
    check("rt_rd_wnr", bus0.M_WNR, 0);
    @(negedge clk);
    check("rt_rd_pulse", bus0.M_REQ, 0);
    k = 0;
    while (!bus0.RSP_VALID && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rt_rsp_valid", bus0.RSP_VALID, 1);
    check("rt_rsp_data", bus0.RSP_DATA, 8'hA7);
    check("rt_rsp_pid", bus0.RSP_PID, 2);
    check("rt_rsp_err", bus0.RSP_ERR, 0);
    pop0();
    check("rt_rsp_popped", bus0.RSP_VALID, 0);
    wait_idle0("rt_idle", 40);

    // response backpressure: 4 reads complete, the 5th waits
    c0 = req_cnt0;
    for (int i = 0; i < 5; i++)
      push0(1'b0, 2'd3, 4'(i), 8'h00, acc);
    repeat (80) @(negedge clk);
    check("rbp_req_count", req_cnt0 - c0, 4);
    check("rbp_rsp_valid", bus0.RSP_VALID, 1);
    check("rbp_busy", bus0.BUSY, 1);
    pop0();
    wait_req0("rbp_fifth_req", 20);
    wait_idle0("rbp_idle", 60);
    for (int i = 1; i < 5; i++) begin
      check("rbp_data", bus0.RSP_DATA, 8'h30 + i);
      check("rbp_pid_err", {bus0.RSP_PID, bus0.RSP_ERR}, 3'b110);
      pop0();
    end
    check("rbp_drained", bus0.RSP_VALID, 0);

    // gap spacing with GAP_CYCLES=4, then level ACK
    ack_en = 1'b0;
    @(negedge clk);
    push0(1'b1, 2'd1, 4'h7, 8'h11, acc);
    push0(1'b1, 2'd1, 4'h8, 8'h22, acc);
    wait_req0("gap4_req", 10);
    repeat (2) @(negedge clk);
    man_ack = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus0.M_REQ && k < 20);
    check("gap4_spacing", k, 6);
    repeat (5) @(negedge clk);
    check("level_ack_hold", bus0.M_CSN, 4'b1101);
    check("level_ack_busy", bus0.BUSY, 1);
    man_ack = 1'b0;
    @(negedge clk);
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    man_ack = 1'b0;
    wait_idle0("level_ack_idle", 20);
    check("level_ack_noto", bus0.TIMEOUT_ERR, 0);

    // gap spacing with GAP_CYCLES=0
    bus1.CMD_VALID = 1'b1;
    bus1.CMD_WNR   = 1'b1;
    bus1.CMD_PID   = 2'd0;
    bus1.CMD_ADDR  = 4'h1;
    bus1.CMD_DATA  = 8'h01;
    @(negedge clk);
    bus1.CMD_ADDR  = 4'h2;
    @(negedge clk);
    bus1.CMD_VALID = 1'b0;
    k = 0;
    while (!bus1.M_REQ && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("gap0_req", bus1.M_REQ, 1);
    check("gap0_csn", bus1.M_CSN, 4'b1110);
    repeat (2) @(negedge clk);
    man_ack1 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus1.M_REQ && k < 20);
    check("gap0_spacing", k, 2);
    man_ack1 = 1'b0;
    @(negedge clk);
    man_ack1 = 1'b1;
    repeat (2) @(negedge clk);
    man_ack1 = 1'b0;
    @(negedge clk);
    check("gap0_idle", {bus1.BUSY, bus1.M_CSN}, 5'b01111);

    // timeout on a read, then a queued write completes
    push0(1'b0, 2'd1, 4'h3, 8'h00, acc);
    push0(1'b1, 2'd0, 4'h9, 8'h5A, acc);
    wait_req0("to_req", 5);
    repeat (16) @(negedge clk);
    check("to_early", {bus0.RSP_VALID, bus0.TIMEOUT_ERR}, 0);
    @(negedge clk);
    check("to_rsp_valid", bus0.RSP_VALID, 1);
    check("to_rsp", {bus0.RSP_DATA, bus0.RSP_PID, bus0.RSP_ERR},
          {8'h00, 2'd1, 1'b1});
    check("to_flag", bus0.TIMEOUT_ERR, 1);
    ack_en = 1'b1;
    wait_idle0("to_next_idle", 60);
    check("to_next_write", mem[0][9], 8'h5A);
    check("to_sticky", bus0.TIMEOUT_ERR, 1);
    bus0.ERR_CLR = 1'b1;
    @(negedge clk);
    bus0.ERR_CLR = 1'b0;
    check("to_clear", bus0.TIMEOUT_ERR, 0);
    pop0();
    check("to_popped", bus0.RSP_VALID, 0);

    // command backpressure, then reset mid-transaction
    ack_en = 1'b0;
    @(negedge clk);
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      push0(1'b1, 2'd1, 4'(i), 8'(i), acc);
      nacc += int'(acc);
    end
    check("cbp_accepted", nacc, 5);
    check("cbp_not_ready", bus0.CMD_READY, 0);
    man_ack = 1'b1;
    repeat (2) @(negedge clk);
    man_ack = 1'b0;
    k = 0;
    while (!bus0.CMD_READY && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("cbp_ready_back", bus0.CMD_READY, 1);
    wait_req0("mid_req", 5);
    @(negedge clk);
    check("mid_wait_csn", bus0.M_CSN, 4'b1101);
    rstn = 1'b0;
    #1;
    check("mid_rst_csn", bus0.M_CSN, 4'hF);
    check("mid_rst_busy", bus0.BUSY, 0);
    check("mid_rst_rsp", bus0.RSP_VALID, 0);
    check("mid_rst_ready", bus0.CMD_READY, 1);
    @(negedge clk);
    rstn = 1'b1;
    c0 = req_cnt0;
    repeat (30) @(negedge clk);
    check("mid_no_req", req_cnt0 - c0, 0);
    check("mid_idle", bus0.BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
